sha256_sched_unit: RTL
======================

# sha256_sched_unit

Sequential SHA-256 message-schedule generator that sits upstream of the combinational SHA-2 sigma/sum function unit in the crypto extension datapath. It accepts one 512-bit message block as 16 serial 32-bit words and streams out the 64 schedule words W[0..63], computing W[16..63] internally with the SHA-256 σ0/σ1 functions. It feeds round logic or a test harness over a valid/ready stream, so the schedule does not have to be built in software with per-word SIG0/SIG1 instructions.

## Interface
- No parameters; word width fixed at 32, block length 16, schedule length 64.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous abort; returns the block to IDLE.
- msg_valid_i  in  1  input word valid.
- msg_ready_o  out  1  input word accepted when high together with msg_valid_i.
- msg_word_i  in  32  message word; big-endian word order, first word = W[0].
- w_valid_o  out  1  schedule word valid.
- w_ready_i  in  1  consumer accepts W when high together with w_valid_o.
- w_word_o  out  32  schedule word W[t].
- w_idx_o  out  6  index t of w_word_o, 0..63.
- block_done_o  out  1  one-cycle pulse on acceptance of W[63].
- busy_o  out  1  high in LOAD or EXPAND.

## Operation
- Storage: 16×32 shift window win[0..15], 4-bit load counter, 6-bit output counter, 2-bit FSM.
- σ0(x) = ROTR7 ^ ROTR18 ^ SHR3; σ1(x) = ROTR17 ^ ROTR19 ^ SHR10. Rotates are true 32-bit rotates with no zero fill.
- FSM states: IDLE, LOAD, EXPAND.
- IDLE: msg_ready_o=1. An accepted word writes win[15], shifts the window down by one (win[i] <= win[i+1]), sets the load counter to 1, and moves to LOAD.
- LOAD: msg_ready_o=1. Each accepted word shifts into win[15] the same way. On acceptance of the 16th word, go to EXPAND with win[0..15] = W[0..15] and the output counter at 0.
- EXPAND: msg_ready_o=0, w_valid_o=1, w_word_o=win[0], w_idx_o = output counter.
- EXPAND handshake: shift the window down and write win[15] <= σ1(win[14]) + win[9] + σ0(win[1]) + win[0], added mod 2^32 with carries discarded. Increment the output counter.
- End of block: the handshake at index 63 pulses block_done_o and returns to IDLE. The window contents are don't-care afterward; the next block fully overwrites them.
- Back-pressure: while w_ready_i=0 the window, counter and outputs hold stable. w_valid_o never drops mid-block.
- flush_i outranks every handshake in the same cycle. It clears both counters and returns to IDLE, with no block_done_o pulse. The window is not cleared.
- msg_valid_i is ignored in EXPAND. w_ready_i is ignored outside EXPAND.

## Timing
- Reset values: FSM=IDLE, counters=0, win=0, msg_ready_o=1, w_valid_o=0, w_word_o=0, w_idx_o=0, block_done_o=0, busy_o=0.
- Reset is effective immediately, including mid-LOAD or mid-EXPAND. A partial block is discarded.
- Latency: W[0] is valid in the cycle after the 16th input handshake.
- Throughput: one input word per cycle in IDLE/LOAD, one output word per cycle in EXPAND. The minimum block period is 80 cycles, with no overlap between blocks.
- block_done_o is combinational (w_valid_o & w_ready_i & idx==63) or registered. Either way it must be exactly one cycle, coincident with the W[63] handshake.
- The critical path is σ1 + σ0 + a 4-input 32-bit add, one level per cycle.

## Test plan
- All-zero block, w_ready_i=1 constantly → 64 words all 0x00000000, indices 0..63, block_done_o one cycle at idx 63, then msg_ready_o=1.
- "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018) → W[0..15] echo the input, W16=0x61626380, W17=0x000F0000; compare all 64 words to the software model.
- W0=0, W1=0x00000080, rest 0 → W16=0x00200011 (σ0 path), W17=0x00000080.
- Randomized w_ready_i stalls and gaps on msg_valid_i, 100 random blocks → outputs hold stable during stalls and match the model word-for-word; no lost or duplicated indices.
- flush_i asserted after 9 loaded words, then again at idx 30 of EXPAND → IDLE next cycle, no block_done_o; the following full block is correct.
- rst_i pulsed asynchronously mid-EXPAND (idx 40) → all outputs at reset values before the next clock edge; the next block is correct from idx 0.

Source files
------------

// File: rtl/sha256_sched_unit.sv
// SHA-256 message schedule generator: loads 16 message words serially, then
// streams W[0..63] over a valid/ready port, expanding W[16..63] on the fly.
module sha256_sched_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        msg_valid_i,
    output logic        msg_ready_o,
    input  logic [31:0] msg_word_i,
    output logic        w_valid_o,
    input  logic        w_ready_i,
    output logic [31:0] w_word_o,
    output logic [5:0]  w_idx_o,
    output logic        block_done_o,
    output logic        busy_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, EXPAND = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [15:0][31:0] win_q;
    logic [3:0]        ld_cnt_q;
    logic [5:0]        out_cnt_q;
    logic              in_hs, w_hs;
    logic [31:0]       w_next;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign msg_ready_o  = (state_q != EXPAND);
    assign w_valid_o    = (state_q == EXPAND);
    assign busy_o       = (state_q != IDLE);
    assign in_hs        = msg_valid_i & msg_ready_o;
    assign w_hs         = w_valid_o & w_ready_i;
    assign w_word_o     = w_valid_o ? win_q[0] : 32'd0;
    assign w_idx_o      = out_cnt_q;
    // A flush in the same cycle cancels the final handshake, so no done pulse.
    assign block_done_o = w_hs & (out_cnt_q == 6'd63) & ~flush_i;

    // W[t+16] from the window holding W[t..t+15].
    assign w_next = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_hs) state_d = LOAD;
            LOAD:    if (in_hs && ld_cnt_q == 4'd15) state_d = EXPAND;
            EXPAND:  if (w_hs && out_cnt_q == 6'd63) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            win_q     <= '0;
            ld_cnt_q  <= 4'd0;
            out_cnt_q <= 6'd0;
        end else begin
            state_q <= state_d;
            if (flush_i) begin
                ld_cnt_q  <= 4'd0;
                out_cnt_q <= 6'd0;
            end else if (in_hs) begin
                // Load counter wraps to 0 on the 16th word, ready for the next block.
                win_q    <= {msg_word_i, win_q[15:1]};
                ld_cnt_q <= ld_cnt_q + 4'd1;
            end else if (w_hs) begin
                win_q     <= {w_next, win_q[15:1]};
                out_cnt_q <= out_cnt_q + 6'd1;
            end
        end
    end
endmodule
